threewire_cmd_queue: RTL
========================

THREEWIRE_CMD_QUEUE -- requirements
Module: threewire_cmd_queue

Interface
REQ-001 SHALL have parameters: ADDR_BITS, default 9, address width; DATA_BITS, default 16, data width; CMD_DEPTH, default 4, command FIFO entries (power of 2); RSP_DEPTH, default 2, read-response FIFO entries (power of 2); TIMEOUT_CYCLES, default 1024, watchdog limit.
REQ-002 SHALL have ports, in order:
- in_clk  input  1  sole clock, rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_cmd_valid  input  1  host command offered.
- out_cmd_ready  output  1  command FIFO not full.
- in_cmd_wr  input  1  1 = write, 0 = read.
- in_cmd_addr  input  ADDR_BITS  register address.
- in_cmd_data  input  DATA_BITS  write data; ignored for reads.
- out_rsp_valid  output  1  read response available.
- in_rsp_ready  input  1  host consumes response.
- out_rsp_addr  output  ADDR_BITS  address of the read.
- out_rsp_data  output  DATA_BITS  data returned by the read.
- out_tw_start  output  1  start request to the threewire master.
- out_tw_mode_wr  output  1  transfer direction to the master.
- out_tw_addr  output  ADDR_BITS  transfer address to the master.
- out_tw_wr_data  output  DATA_BITS  transfer write data to the master.
- in_tw_rd_data  input  DATA_BITS  master read data, valid once busy falls.
- in_tw_busy  input  1  master io-in-progress flag.
- out_err  output  1  sticky watchdog error.
- out_idle  output  1  both FIFOs empty, FSM in IDLE.

Function
REQ-003 SHALL accept a command on a rising edge where in_cmd_valid and out_cmd_ready are both 1; out_cmd_ready SHALL be 0 when CMD_DEPTH entries are held, even if a pop occurs in the same cycle.
REQ-004 SHALL execute commands strictly in FIFO order, one at a time, with FSM states IDLE, LAUNCH, ACTIVE, DONE.
REQ-005 SHALL move IDLE->LAUNCH when the command FIFO is non-empty and, for a read at the head, the response FIFO is not full; otherwise it SHALL stay in IDLE.
REQ-006 SHALL, in LAUNCH, drive out_tw_start=1 and hold out_tw_mode_wr/addr/wr_data stable from the head entry; on the first cycle in_tw_busy=1 it SHALL deassert start and move to ACTIVE.
REQ-007 SHALL stay in ACTIVE while in_tw_busy=1; on in_tw_busy=0 it SHALL move to DONE.
REQ-008 SHALL, in DONE, pop the head command and, for a read, push {addr, in_tw_rd_data} into the response FIFO, then return to IDLE (one cycle in DONE).
REQ-009 SHALL keep out_tw_* address/data/mode registered and unchanged from LAUNCH entry through DONE.
REQ-010 SHALL present the oldest response on out_rsp_*; pop on in_rsp_ready=1 with out_rsp_valid=1; simultaneous push and pop SHALL both take effect.
REQ-011 SHALL issue writes while the response FIFO is full; only reads stall.
REQ-012 SHALL use pointer wrap modulo depth with an extra occupancy bit (or counter) to distinguish full from empty.
REQ-013 SHALL drive out_idle=1 only when in IDLE with both FIFOs empty.

Reset
REQ-014 SHALL, on in_rst=1 at a rising edge, empty both FIFOs, enter IDLE, and set out_tw_start=0, out_tw_mode_wr=0, out_tw_addr=0, out_tw_wr_data=0, out_rsp_valid=0, out_rsp_addr=0, out_rsp_data=0, out_err=0, out_cmd_ready=1, out_idle=1.
REQ-015 SHALL, on reset during LAUNCH or ACTIVE, drop the in-flight command without a response; the master's recovery is its own concern.

Configuration
REQ-016 SHALL compile the watchdog only when THREEWIRE_CMDQ_TIMEOUT_EN is defined: a counter cleared on LAUNCH entry counts cycles in LAUNCH+ACTIVE; reaching TIMEOUT_CYCLES SHALL deassert out_tw_start, set out_err=1 (sticky until reset), pop the command without a response, and return to IDLE.
REQ-017 SHALL, without THREEWIRE_CMDQ_TIMEOUT_EN, wait indefinitely in LAUNCH/ACTIVE and tie out_err to 0.

Verification
REQ-018 Write 0x04E<-0x0049 with the slave model answering -> one start pulse, slave sees mode=1, addr=0x04E, data=0x0049; no response pushed.
REQ-019 Read 0x003 with the slave returning 0x003D -> out_rsp_valid rises one cycle after busy falls, rsp_addr=0x003, rsp_data=0x003D.
REQ-020 Push 5 commands back-to-back with the master stalled -> out_cmd_ready=0 after the 4th; the 5th is accepted only after the first DONE.
REQ-021 Three reads with in_rsp_ready=0 -> two responses held, third read not launched (out_tw_start stays 0) until one response is popped.
REQ-022 With THREEWIRE_CMDQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, busy held 0 after start -> out_err=1 after 16 cycles, FSM in IDLE, next command executes normally.
REQ-023 Assert in_rst in ACTIVE -> next cycle all outputs match REQ-014; queued commands lost.

Source files
------------

// File: rtl/threewire_cmd_queue.sv
// Command queue in front of a threewire master.
// Host commands are buffered in a small FIFO and issued to the master one at a time, in order.
// Read results come back through a second FIFO.
// Optional watchdog: define THREEWIRE_CMDQ_TIMEOUT_EN to build it. Without it, out_err is tied to 0.
module threewire_cmd_queue #(
  parameter int unsigned ADDR_BITS      = 9,
  parameter int unsigned DATA_BITS      = 16,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned RSP_DEPTH      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_cmd_valid,
  output logic                 out_cmd_ready,
  input  logic                 in_cmd_wr,
  input  logic [ADDR_BITS-1:0] in_cmd_addr,
  input  logic [DATA_BITS-1:0] in_cmd_data,
  output logic                 out_rsp_valid,
  input  logic                 in_rsp_ready,
  output logic [ADDR_BITS-1:0] out_rsp_addr,
  output logic [DATA_BITS-1:0] out_rsp_data,
  output logic                 out_tw_start,
  output logic                 out_tw_mode_wr,
  output logic [ADDR_BITS-1:0] out_tw_addr,
  output logic [DATA_BITS-1:0] out_tw_wr_data,
  input  logic [DATA_BITS-1:0] in_tw_rd_data,
  input  logic                 in_tw_busy,
  output logic                 out_err,
  output logic                 out_idle
);

  localparam int unsigned CmdPtrW = $clog2(CMD_DEPTH);
  localparam int unsigned RspPtrW = $clog2(RSP_DEPTH);
  localparam int unsigned CmdW    = 1 + ADDR_BITS + DATA_BITS;
  localparam int unsigned RspW    = ADDR_BITS + DATA_BITS;

  typedef enum logic [1:0] {StIdle, StLaunch, StActive, StDone} state_e;

  state_e                 state_q;
  logic [CmdW-1:0]        cmd_mem [CMD_DEPTH];
  logic [CmdPtrW:0]       cmd_wptr_q, cmd_rptr_q;
  logic [RspW-1:0]        rsp_mem [RSP_DEPTH];
  logic [RspPtrW:0]       rsp_wptr_q, rsp_rptr_q;
  logic                   tw_start_q, tw_mode_wr_q;
  logic [ADDR_BITS-1:0]   tw_addr_q;
  logic [DATA_BITS-1:0]   tw_wr_data_q;
  logic [CmdW-1:0]        cmd_head;
  logic [RspW-1:0]        rsp_head;
  logic cmd_empty, cmd_full, rsp_empty, rsp_full;
  logic cmd_push, cmd_pop, rsp_push, rsp_pop, launch_ok, timeout_hit;

  // FIFO status and handshakes; the extra pointer MSB separates full from empty
  always_comb begin
    cmd_head  = cmd_mem[cmd_rptr_q[CmdPtrW-1:0]];
    rsp_head  = rsp_mem[rsp_rptr_q[RspPtrW-1:0]];
    cmd_empty = (cmd_wptr_q == cmd_rptr_q);
    cmd_full  = (cmd_wptr_q[CmdPtrW] != cmd_rptr_q[CmdPtrW]) &&
                (cmd_wptr_q[CmdPtrW-1:0] == cmd_rptr_q[CmdPtrW-1:0]);
    rsp_empty = (rsp_wptr_q == rsp_rptr_q);
    rsp_full  = (rsp_wptr_q[RspPtrW] != rsp_rptr_q[RspPtrW]) &&
                (rsp_wptr_q[RspPtrW-1:0] == rsp_rptr_q[RspPtrW-1:0]);
    cmd_push  = in_cmd_valid && !cmd_full;
    cmd_pop   = (state_q == StDone) || timeout_hit;
    rsp_push  = (state_q == StDone) && !tw_mode_wr_q && !rsp_full;
    rsp_pop   = in_rsp_ready && !rsp_empty;
    // Only reads need a free response slot; writes may go while responses back up
    launch_ok = !cmd_empty && (cmd_head[CmdW-1] || !rsp_full);
  end

  // Command storage, entries are {wr, addr, data}
  always_ff @(posedge in_clk) begin
    if (cmd_push) cmd_mem[cmd_wptr_q[CmdPtrW-1:0]] <= {in_cmd_wr, in_cmd_addr, in_cmd_data};
  end

  // Response storage, entries are {addr, data}
  always_ff @(posedge in_clk) begin
    if (rsp_push) rsp_mem[rsp_wptr_q[RspPtrW-1:0]] <= {tw_addr_q, in_tw_rd_data};
  end

  // FIFO pointers
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
      rsp_wptr_q <= '0;
      rsp_rptr_q <= '0;
    end else begin
      if (cmd_push) cmd_wptr_q <= cmd_wptr_q + 1'b1;
      if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + 1'b1;
      if (rsp_push) rsp_wptr_q <= rsp_wptr_q + 1'b1;
      if (rsp_pop)  rsp_rptr_q <= rsp_rptr_q + 1'b1;
    end
  end

  // Sequencer: launch head command, follow master busy, retire
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= StIdle;
      tw_start_q   <= 1'b0;
      tw_mode_wr_q <= 1'b0;
      tw_addr_q    <= '0;
      tw_wr_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (launch_ok) begin
            state_q      <= StLaunch;
            tw_start_q   <= 1'b1;
            tw_mode_wr_q <= cmd_head[CmdW-1];
            tw_addr_q    <= cmd_head[DATA_BITS +: ADDR_BITS];
            tw_wr_data_q <= cmd_head[DATA_BITS-1:0];
          end
        end
        StLaunch: begin
          if (timeout_hit) begin
            tw_start_q <= 1'b0;
            state_q    <= StIdle;
          end else if (in_tw_busy) begin
            tw_start_q <= 1'b0;
            state_q    <= StActive;
          end
        end
        StActive: begin
          if (timeout_hit)      state_q <= StIdle;
          else if (!in_tw_busy) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef THREEWIRE_CMDQ_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wd_q;
  logic           err_q;
  logic           in_flight;

  assign in_flight   = (state_q == StLaunch) || (state_q == StActive);
  assign timeout_hit = in_flight && (wd_q == WdW'(TIMEOUT_CYCLES - 1));
  assign out_err     = err_q;

  // Watchdog over LAUNCH+ACTIVE; error flag is sticky until reset
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StIdle && launch_ok) wd_q <= '0;
      else if (in_flight)                 wd_q <= wd_q + 1'b1;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign out_err     = 1'b0;
`endif

  // Output mapping; response fields read as zero when nothing is held
  always_comb begin
    out_cmd_ready  = !cmd_full;
    out_rsp_valid  = !rsp_empty;
    out_rsp_addr   = rsp_empty ? '0 : rsp_head[DATA_BITS +: ADDR_BITS];
    out_rsp_data   = rsp_empty ? '0 : rsp_head[DATA_BITS-1:0];
    out_tw_start   = tw_start_q;
    out_tw_mode_wr = tw_mode_wr_q;
    out_tw_addr    = tw_addr_q;
    out_tw_wr_data = tw_wr_data_q;
    out_idle       = (state_q == StIdle) && cmd_empty && rsp_empty;
  end

endmodule
